// File: rtl/gpio_in_port_pkg.sv
// Shared address map for the memory-mapped LED and GPIO input peripherals.
package gpio_in_port_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] LED_ADDR  = 32'h0000_1000;
  localparam logic [31:0] GPIO_BASE = 32'h0000_1004;

  localparam logic [31:0] OFF_LEVEL = 32'h0000_0000;
  localparam logic [31:0] OFF_EDGE  = 32'h0000_0004;
  localparam logic [31:0] OFF_MASK  = 32'h0000_0008;

  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_EDGE  = 2'd1,
    REG_MASK  = 2'd2,
    REG_NONE  = 2'd3
  } gpio_reg_e;

  // Word-aligned offset decode; byte-lane bits of the address are ignored.
  function automatic gpio_reg_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = (addr & 32'hFFFF_FFFC) - (base & 32'hFFFF_FFFC);
    case (off)
      OFF_LEVEL: decode_reg = REG_LEVEL;
      OFF_EDGE:  decode_reg = REG_EDGE;
      OFF_MASK:  decode_reg = REG_MASK;
      default:   decode_reg = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input line: 2-FF synchroniser, stability counter, debounced level and rise pulse.
module gpio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             level_q, level_d;

  // Accept the synchronised value only after it has differed from the level long enough.
  always_comb begin
    sync_d  = {sync_q[0], din};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_c = level_d & ~level_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/gpio_in_port.sv
// GPIO input peripheral: debounced LEVEL, sticky W1C EDGE flags, MASK and level irq.
module gpio_in_port
  import gpio_in_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = GPIO_BASE,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic              clk_20M,
  input  logic              rst_n,
  input  logic [31:0]       daddr,
  input  logic [31:0]       wdata,
  input  logic              dmem_r,
  input  logic              dmem_w,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [31:0]       rdata,
  output logic              irq
);

  logic [WIDTH-1:0]  level;
  logic [WIDTH-1:0]  rise_c;
  logic [WIDTH-1:0]  edge_flags_q, edge_flags_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;
  gpio_reg_e         reg_sel_c;
  logic              unused_wdata_c;

  assign unused_wdata_c = ^wdata[DATA_W-1:WIDTH];

  // Per-line synchroniser and debouncer.
  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    gpio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk_20M),
      .rst_n  (rst_n),
      .din    (gpio_in[i]),
      .level  (level[i]),
      .rise_c (rise_c[i])
    );
  end

  // Register decode, W1C/RW updates (new rise beats clear) and read mux on pre-write values.
  always_comb begin
    reg_sel_c    = decode_reg(daddr, BASE_ADDR);
    edge_flags_d = edge_flags_q;
    mask_d       = mask_q;
    rdata_d      = '0;
    if (dmem_w) begin
      case (reg_sel_c)
        REG_EDGE: edge_flags_d = edge_flags_q & ~wdata[WIDTH-1:0];
        REG_MASK: mask_d       = wdata[WIDTH-1:0];
        default:  ;
      endcase
    end
    edge_flags_d = edge_flags_d | rise_c;
    if (dmem_r) begin
      case (reg_sel_c)
        REG_LEVEL: rdata_d = DATA_W'(level);
        REG_EDGE:  rdata_d = DATA_W'(edge_flags_q);
        REG_MASK:  rdata_d = DATA_W'(mask_q);
        default:   rdata_d = '0;
      endcase
    end
    irq_d = |(edge_flags_d & mask_d);
  end

  // Register file and output registers.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      edge_flags_q <= '0;
      mask_q       <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      edge_flags_q <= edge_flags_d;
      mask_q       <= mask_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_gpio_in_port.sv
// Self-checking bench for gpio_in_port against a cycle-level behavioural model.
module tb_gpio_in_port;

  localparam int unsigned DC = 4;
  localparam int unsigned W  = 8;

  logic         clk_20M = 1'b0;
  logic         rst_n   = 1'b0;
  logic [31:0]  daddr   = '0;
  logic [31:0]  wdata   = '0;
  logic         dmem_r  = 1'b0;
  logic         dmem_w  = 1'b0;
  logic [W-1:0] gpio_in = '0;
  logic [31:0]  rdata;
  logic         irq;

  int checks = 0;
  int errors = 0;

  // Model state: recent pin samples (index = edges ago) and the architectural registers.
  logic [W-1:0] samp [0:DC+1];
  logic [W-1:0] m_lvl, m_edge, m_mask;
  logic [31:0]  m_rdata;
  logic         m_irq;

  gpio_in_port #(
    .BASE_ADDR       (32'h0000_1004),
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk_20M (clk_20M),
    .rst_n   (rst_n),
    .daddr   (daddr),
    .wdata   (wdata),
    .dmem_r  (dmem_r),
    .dmem_w  (dmem_w),
    .gpio_in (gpio_in),
    .rdata   (rdata),
    .irq     (irq)
  );

  always #25 clk_20M = ~clk_20M;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic int reg_index(input logic [31:0] a);
    case (a & 32'hFFFF_FFFC)
      32'h0000_1004: return 0;
      32'h0000_1008: return 1;
      32'h0000_100C: return 2;
      default:       return -1;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k <= DC + 1; k++) samp[k] = '0;
    m_lvl = '0; m_edge = '0; m_mask = '0; m_rdata = '0; m_irq = 1'b0;
  endtask

  // A line's level flips once the DC synchronised samples before now all disagree with it.
  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [W-1:0] pin);
    int           idx;
    logic [W-1:0] nl, rise;
    bit           all_diff;
    idx = reg_index(a);
    if (r && idx == 0)      m_rdata = 32'(m_lvl);
    else if (r && idx == 1) m_rdata = 32'(m_edge);
    else if (r && idx == 2) m_rdata = 32'(m_mask);
    else                    m_rdata = '0;
    for (int k = DC + 1; k >= 1; k--) samp[k] = samp[k-1];
    samp[0] = pin;
    nl = m_lvl;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DC + 1; k++)
        if (samp[k][i] == m_lvl[i]) all_diff = 1'b0;
      if (all_diff) nl[i] = ~m_lvl[i];
    end
    rise = nl & ~m_lvl;
    if (w && idx == 1) m_edge = m_edge & ~wd[W-1:0];
    if (w && idx == 2) m_mask = wd[W-1:0];
    m_edge = m_edge | rise;
    m_lvl  = nl;
    m_irq  = |(m_edge & m_mask);
  endtask

  // One bus cycle: drive at the falling edge, model the rising edge, compare 1 time unit later.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [W-1:0] pin);
    dmem_r = r; dmem_w = w; daddr = a; wdata = wd; gpio_in = pin;
    @(posedge clk_20M);
    model_step(r, w, a, wd, pin);
    #1;
    check_eq("rdata_model", rdata, m_rdata);
    check_eq("irq_model", 32'(irq), 32'(m_irq));
    @(negedge clk_20M);
  endtask

  task automatic rd(input logic [31:0] a, input logic [W-1:0] pin);
    cyc(1'b1, 1'b0, a, '0, pin);
  endtask

  task automatic do_reset(input logic [W-1:0] pin);
    dmem_r = 1'b0; dmem_w = 1'b0; gpio_in = pin;
    rst_n = 1'b0;
    #1;
    check_eq("reset_rdata", rdata, 32'h0);
    check_eq("reset_irq", 32'(irq), 32'h0);
    model_clear();
    @(negedge clk_20M);
    @(negedge clk_20M);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0]  pin;
    logic [31:0]   a;
    model_clear();
    repeat (2) @(negedge clk_20M);
    check_eq("por_rdata", rdata, 32'h0);
    check_eq("por_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;

    rd(32'h1004, 8'h00); check_eq("rst_level", rdata, 32'h0);
    rd(32'h1008, 8'h00); check_eq("rst_edge", rdata, 32'h0);
    rd(32'h100C, 8'h00); check_eq("rst_mask", rdata, 32'h0);

    for (int k = 1; k <= 7; k++) begin
      rd(32'h1004, 8'h05);
      check_eq("level_ramp", rdata, (k == 7) ? 32'h05 : 32'h0);
    end
    rd(32'h1008, 8'h05); check_eq("edge_05", rdata, 32'h05);

    repeat (2) cyc(1'b0, 1'b0, 32'h0, '0, 8'h07);
    repeat (8) cyc(1'b0, 1'b0, 32'h0, '0, 8'h05);
    rd(32'h1004, 8'h05); check_eq("glitch_level", rdata, 32'h05);
    rd(32'h1008, 8'h05); check_eq("glitch_edge", rdata, 32'h05);

    cyc(1'b0, 1'b1, 32'h100C, 32'h04, 8'h05); check_eq("irq_set", 32'(irq), 32'h1);
    cyc(1'b0, 1'b1, 32'h1008, 32'h04, 8'h05); check_eq("irq_clr", 32'(irq), 32'h0);
    rd(32'h1008, 8'h05); check_eq("edge_w1c", rdata, 32'h01);

    repeat (7) cyc(1'b0, 1'b0, 32'h0, '0, 8'h04);
    rd(32'h1004, 8'h04); check_eq("fall_level", rdata, 32'h04);
    rd(32'h1008, 8'h04); check_eq("fall_ignored", rdata, 32'h01);
    repeat (5) cyc(1'b0, 1'b0, 32'h0, '0, 8'h05);
    cyc(1'b0, 1'b1, 32'h1008, 32'h01, 8'h05);
    rd(32'h1008, 8'h05); check_eq("set_wins", rdata, 32'h01);

    rd(32'h1000, 8'h05); check_eq("led_addr", rdata, 32'h0);
    rd(32'h1010, 8'h05); check_eq("past_block", rdata, 32'h0);
    rd(32'h1006, 8'h05); check_eq("byte_lane", rdata, 32'h05);
    cyc(1'b1, 1'b1, 32'h100C, 32'hFFFF_FF01, 8'h05); check_eq("rw_old", rdata, 32'h04);
    rd(32'h100C, 8'h05); check_eq("rw_new", rdata, 32'h01);
    check_eq("irq_mask1", 32'(irq), 32'h1);

    cyc(1'b0, 1'b0, 32'h0, '0, 8'hFF);
    cyc(1'b0, 1'b0, 32'h0, '0, 8'hFF);
    rd(32'h1004, 8'hFF); check_eq("pre_rst_level", rdata, 32'h05);
    do_reset(8'hFF);
    for (int k = 1; k <= 7; k++) begin
      rd(32'h1004, 8'hFF);
      check_eq("post_rst_ramp", rdata, (k == 7) ? 32'hFF : 32'h0);
    end
    rd(32'h1008, 8'hFF); check_eq("post_rst_edge", rdata, 32'hFF);

    pin = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) pin = pin ^ (8'($urandom) & 8'($urandom));
      case ($urandom_range(0, 5))
        0: a = 32'h1000;
        1: a = 32'h1004;
        2: a = 32'h1008;
        3: a = 32'h100C;
        4: a = 32'h1010;
        default: a = $urandom;
      endcase
      a[1:0] = 2'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset(pin);
      else cyc(1'($urandom), ($urandom_range(0, 3) == 0), a, $urandom, pin);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
